// File: rtl/jb_oran_lphy_stat_pkg.sv
// Shared constants for the O-RAN LPHY statistics bank: counter/error slot
// indices, default bank sizes and the default counter word type.
package jb_oran_lphy_stat_pkg;

  localparam int NUM_CNT_DEF = 25;
  localparam int NUM_ERR_DEF = 16;
  localparam int CNT_W_DEF   = 32;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  // Event counter slots (index into evt_vld / evt_inc / rd_addr)
  localparam int CNT_RUNT_T0          = 0;
  localparam int CNT_RUNT_T1          = 1;
  localparam int CNT_WIN_T2_T1_DL     = 2;
  localparam int CNT_WIN_T2_T1_UL     = 3;
  localparam int CNT_T1_REQS_DL0      = 4;
  localparam int CNT_T1_REQS_DL1      = 5;
  localparam int CNT_T1_REQS_UL0      = 6;
  localparam int CNT_T1_REQS_UL1      = 7;
  localparam int CNT_DL_CPLANE_PKTS   = 8;
  localparam int CNT_DL_UPLANE_PKTS   = 9;
  localparam int CNT_UL_CPLANE_PKTS   = 10;
  localparam int CNT_UL_UPLANE_PKTS   = 11;
  localparam int CNT_PRACH_CPLANE     = 12;
  localparam int CNT_PRACH_UPLANE     = 13;
  localparam int CNT_DL_LATE_PKTS     = 14;
  localparam int CNT_UL_LATE_PKTS     = 15;
  localparam int CNT_DL_EARLY_PKTS    = 16;
  localparam int CNT_UL_EARLY_PKTS    = 17;
  localparam int CNT_DL_DROPPED       = 18;
  localparam int CNT_UL_DROPPED       = 19;
  localparam int CNT_PRACH_DROPPED    = 20;
  localparam int CNT_SECT_WRITES      = 21;
  localparam int CNT_SYM_TICKS        = 22;
  localparam int CNT_SLOT_TICKS       = 23;
  localparam int CNT_FRAME_TICKS      = 24;

  // Sticky error slots (index into err_in / err_clr / err_sticky)
  localparam int ERR_UL_VLD_WO_RDY0     = 0;
  localparam int ERR_UL_VLD_WO_RDY1     = 1;
  localparam int ERR_DL_VLD_WO_RDY0     = 2;
  localparam int ERR_DL_VLD_WO_RDY1     = 3;
  localparam int ERR_DL_CPLANE_OVFL0    = 4;
  localparam int ERR_DL_CPLANE_OVFL1    = 5;
  localparam int ERR_UL_CPLANE_OVFL0    = 6;
  localparam int ERR_UL_CPLANE_OVFL1    = 7;
  localparam int ERR_PRACH_CPLANE_OVFL0 = 8;
  localparam int ERR_PRACH_CPLANE_OVFL1 = 9;
  localparam int ERR_DL_UPLANE_UNFL     = 10;
  localparam int ERR_UL_UPLANE_OVFL     = 11;
  localparam int ERR_PRACH_UPLANE_OVFL  = 12;
  localparam int ERR_SECT_ID_UNKNOWN    = 13;
  localparam int ERR_SECT_WR_ORDER      = 14;
  localparam int ERR_SECT_WR_TOO_LONG   = 15;

endpackage

// File: rtl/jb_oran_lphy_stat_cnt_bank_if.sv
// Regmap-side snapshot and read channel of the statistics bank.
interface jb_oran_lphy_stat_cnt_bank_if
  import jb_oran_lphy_stat_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              snap_req;
  logic              snap_done;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_vld;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_err;

  modport master (
    output snap_req, rd_req, rd_addr,
    input  snap_done, rd_vld, rd_data, rd_err
  );

  modport slave (
    input  snap_req, rd_req, rd_addr,
    output snap_done, rd_vld, rd_data, rd_err
  );
endinterface

// File: rtl/jb_oran_lphy_stat_cnt.sv
// One statistics counter: live count, snapshot shadow and sticky overflow flag,
// with saturate-or-wrap arithmetic and optional restart on snapshot.
module jb_oran_lphy_stat_cnt
  import jb_oran_lphy_stat_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int INC_W       = 4,
  parameter int SAT_MODE    = 1,
  parameter int CLR_ON_SNAP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             evt_vld,
  input  logic [INC_W-1:0] evt_inc,
  input  logic             snap,
  input  logic             ovfl_clr,
  output logic [CNT_W-1:0] shadow,
  output logic             ovfl
);

  logic [CNT_W-1:0] live;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] live_nxt;
  logic [INC_W-1:0] inc;
  logic [CNT_W:0]   sum;
  logic             carry;

  // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    base     = ((CLR_ON_SNAP != 0) && snap) ? '0 : live;
    inc      = evt_vld ? evt_inc : '0;
    sum      = {1'b0, base} + {{(CNT_W + 1 - INC_W){1'b0}}, inc};
    carry    = sum[CNT_W];
    live_nxt = sum[CNT_W-1:0];
    if (carry && (SAT_MODE != 0)) live_nxt = '1;
  end

  // NOTE: state updates use non-blocking assignments so shadow captures the pre-edge live value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live   <= '0;
      shadow <= '0;
      ovfl   <= 1'b0;
    end else begin
      live <= live_nxt;
      if (snap) shadow <= live;
      ovfl <= (ovfl & ~ovfl_clr) | carry;
    end
  end

endmodule

// File: rtl/jb_oran_lphy_stat_cnt_bank.sv
// Parametrised O-RAN LPHY statistics bank: NUM_CNT snapshot counters, NUM_ERR
// sticky error flags and a registered single-port read of the shadow values.
module jb_oran_lphy_stat_cnt_bank
  import jb_oran_lphy_stat_pkg::*;
#(
  parameter int NUM_CNT     = NUM_CNT_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int INC_W       = 4,
  parameter int NUM_ERR     = NUM_ERR_DEF,
  parameter int SAT_MODE    = 1,
  parameter int CLR_ON_SNAP = 1,
  parameter int ADDR_W      = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CNT-1:0]       evt_vld,
  input  logic [NUM_CNT*INC_W-1:0] evt_inc,
  jb_oran_lphy_stat_cnt_bank_if.slave bus,
  input  logic [NUM_ERR-1:0]       err_in,
  input  logic [NUM_ERR-1:0]       err_clr,
  output logic [NUM_ERR-1:0]       err_sticky,
  input  logic [NUM_CNT-1:0]       ovfl_clr,
  output logic [NUM_CNT-1:0]       ovfl_sticky
);

  localparam logic [ADDR_W:0] NUM_CNT_A = (ADDR_W + 1)'(NUM_CNT);

  logic [CNT_W-1:0] shadow [NUM_CNT];
  logic [CNT_W-1:0] rd_mux;
  logic             rd_in_range;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    jb_oran_lphy_stat_cnt #(
      .CNT_W       (CNT_W),
      .INC_W       (INC_W),
      .SAT_MODE    (SAT_MODE),
      .CLR_ON_SNAP (CLR_ON_SNAP)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .evt_vld  (evt_vld[i]),
      .evt_inc  (evt_inc[i*INC_W +: INC_W]),
      .snap     (bus.snap_req),
      .ovfl_clr (ovfl_clr[i]),
      .shadow   (shadow[i]),
      .ovfl     (ovfl_sticky[i])
    );
  end

  // Out-of-range addresses fall through to zero.
  always_comb begin
    rd_in_range = ({1'b0, bus.rd_addr} < NUM_CNT_A);
    rd_mux      = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (bus.rd_addr == ADDR_W'(i)) rd_mux = shadow[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.snap_done <= 1'b0;
      bus.rd_vld    <= 1'b0;
      bus.rd_err    <= 1'b0;
      bus.rd_data   <= '0;
      err_sticky    <= '0;
    end else begin
      bus.snap_done <= bus.snap_req;
      bus.rd_vld    <= bus.rd_req;
      bus.rd_err    <= bus.rd_req & ~rd_in_range;
      if (bus.rd_req) bus.rd_data <= rd_mux;
      err_sticky    <= (err_sticky & ~err_clr) | err_in;
    end
  end

endmodule

// File: tb/tb_jb_oran_lphy_stat_cnt_bank.sv
// Directed bench for the statistics bank: a saturating and a wrapping 8-bit instance.
module tb_jb_oran_lphy_stat_cnt_bank;

  localparam int NUM_CNT = 25;
  localparam int CNT_W   = 8;
  localparam int INC_W   = 4;
  localparam int NUM_ERR = 16;
  localparam int ADDR_W  = 6;

  logic clk;
  logic rst_n;

  logic [NUM_CNT-1:0]       evt_vld_s, evt_vld_w;
  logic [NUM_CNT*INC_W-1:0] evt_inc_s, evt_inc_w;
  logic [NUM_ERR-1:0]       err_in_s, err_clr_s, err_sticky_s;
  logic [NUM_ERR-1:0]       err_in_w, err_clr_w, err_sticky_w;
  logic [NUM_CNT-1:0]       ovfl_clr_s, ovfl_sticky_s, ovfl_clr_w, ovfl_sticky_w;

  jb_oran_lphy_stat_cnt_bank_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus_s ();
  jb_oran_lphy_stat_cnt_bank_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus_w ();

  jb_oran_lphy_stat_cnt_bank #(
    .NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .INC_W(INC_W), .NUM_ERR(NUM_ERR),
    .SAT_MODE(1), .CLR_ON_SNAP(1), .ADDR_W(ADDR_W)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .evt_vld(evt_vld_s), .evt_inc(evt_inc_s), .bus(bus_s),
    .err_in(err_in_s), .err_clr(err_clr_s), .err_sticky(err_sticky_s),
    .ovfl_clr(ovfl_clr_s), .ovfl_sticky(ovfl_sticky_s)
  );

  jb_oran_lphy_stat_cnt_bank #(
    .NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .INC_W(INC_W), .NUM_ERR(NUM_ERR),
    .SAT_MODE(0), .CLR_ON_SNAP(1), .ADDR_W(ADDR_W)
  ) dut_wrap (
    .clk(clk), .rst_n(rst_n), .evt_vld(evt_vld_w), .evt_inc(evt_inc_w), .bus(bus_w),
    .err_in(err_in_w), .err_clr(err_clr_w), .err_sticky(err_sticky_w),
    .ovfl_clr(ovfl_clr_w), .ovfl_sticky(ovfl_sticky_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic events_s(input int idx, input int n, input int inc);
    for (int k = 0; k < n; k++) begin
      evt_vld_s = '0;
      evt_inc_s = '0;
      evt_vld_s[idx] = 1'b1;
      evt_inc_s[idx*INC_W +: INC_W] = INC_W'(inc);
      tick();
    end
    evt_vld_s = '0;
    evt_inc_s = '0;
  endtask

  task automatic snap_s(input string name);
    bus_s.snap_req = 1'b1;
    tick();
    bus_s.snap_req = 1'b0;
    check({name, "_snap_done"}, 64'(bus_s.snap_done), 64'd1);
  endtask

  task automatic read_s(input logic [ADDR_W-1:0] addr);
    bus_s.rd_req  = 1'b1;
    bus_s.rd_addr = addr;
    tick();
    bus_s.rd_req  = 1'b0;
  endtask

  typedef struct {
    int               idx;
    int               n;
    int               inc;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0] exp_data;
    logic             exp_err;
    logic             exp_ovfl;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{idx: 3,  n: 20, inc: 15, addr: 6'd3,  exp_data: 8'hFF, exp_err: 1'b0, exp_ovfl: 1'b1};
    vecs[1] = '{idx: 0,  n: 3,  inc: 10, addr: 6'd0,  exp_data: 8'h1E, exp_err: 1'b0, exp_ovfl: 1'b0};
    vecs[2] = '{idx: 24, n: 17, inc: 15, addr: 6'd24, exp_data: 8'hFF, exp_err: 1'b0, exp_ovfl: 1'b0};
    vecs[3] = '{idx: 7,  n: 1,  inc: 0,  addr: 6'd7,  exp_data: 8'h00, exp_err: 1'b0, exp_ovfl: 1'b0};
    vecs[4] = '{idx: 12, n: 18, inc: 15, addr: 6'd12, exp_data: 8'hFF, exp_err: 1'b0, exp_ovfl: 1'b1};
    vecs[5] = '{idx: 1,  n: 5,  inc: 1,  addr: 6'd1,  exp_data: 8'h05, exp_err: 1'b0, exp_ovfl: 1'b0};
    vecs[6] = '{idx: 2,  n: 4,  inc: 2,  addr: 6'd30, exp_data: 8'h00, exp_err: 1'b1, exp_ovfl: 1'b0};
    vecs[7] = '{idx: 2,  n: 4,  inc: 2,  addr: 6'd25, exp_data: 8'h00, exp_err: 1'b1, exp_ovfl: 1'b0};

    rst_n = 1'b0;
    evt_vld_s = '0; evt_inc_s = '0; evt_vld_w = '0; evt_inc_w = '0;
    err_in_s = '0; err_clr_s = '0; err_in_w = '0; err_clr_w = '0;
    ovfl_clr_s = '0; ovfl_clr_w = '0;
    bus_s.snap_req = 1'b0; bus_s.rd_req = 1'b0; bus_s.rd_addr = '0;
    bus_w.snap_req = 1'b0; bus_w.rd_req = 1'b0; bus_w.rd_addr = '0;

    #3;
    check("rst_rd_data", 64'(bus_s.rd_data), 64'd0);
    check("rst_rd_vld", 64'(bus_s.rd_vld), 64'd0);
    check("rst_snap_done", 64'(bus_s.snap_done), 64'd0);
    check("rst_err_sticky", 64'(err_sticky_s), 64'd0);
    check("rst_ovfl_sticky", 64'(ovfl_sticky_s), 64'd0);
    check("rst_wrap_ovfl", 64'(ovfl_sticky_w), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Table: load one counter, snapshot, read back, check and clear its overflow flag.
    for (int v = 0; v < 8; v++) begin
      events_s(vecs[v].idx, vecs[v].n, vecs[v].inc);
      snap_s($sformatf("vec%0d", v));
      read_s(vecs[v].addr);
      check($sformatf("vec%0d_rd_vld", v), 64'(bus_s.rd_vld), 64'd1);
      check($sformatf("vec%0d_rd_data", v), 64'(bus_s.rd_data), 64'(vecs[v].exp_data));
      check($sformatf("vec%0d_rd_err", v), 64'(bus_s.rd_err), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d_ovfl", v), 64'(ovfl_sticky_s[vecs[v].idx]), 64'(vecs[v].exp_ovfl));
      ovfl_clr_s[vecs[v].idx] = 1'b1;
      tick();
      ovfl_clr_s = '0;
      check($sformatf("vec%0d_ovfl_clr", v), 64'(ovfl_sticky_s[vecs[v].idx]), 64'd0);
      check($sformatf("vec%0d_idle_vld", v), 64'(bus_s.rd_vld), 64'd0);
    end

    // Wrap mode: 25 x 10 = 250, one more +10 wraps to 4 with overflow.
    evt_vld_w[0] = 1'b1;
    evt_inc_w[0 +: INC_W] = 4'd10;
    repeat (25) tick();
    check("wrap_no_ovfl_at_250", 64'(ovfl_sticky_w[0]), 64'd0);
    tick();
    evt_vld_w = '0;
    evt_inc_w = '0;
    check("wrap_ovfl_set", 64'(ovfl_sticky_w[0]), 64'd1);
    bus_w.snap_req = 1'b1;
    tick();
    bus_w.snap_req = 1'b0;
    check("wrap_snap_done", 64'(bus_w.snap_done), 64'd1);
    bus_w.rd_req = 1'b1;
    bus_w.rd_addr = 6'd0;
    tick();
    bus_w.rd_req = 1'b0;
    check("wrap_rd_data", 64'(bus_w.rd_data), 64'd4);
    check("wrap_rd_vld", 64'(bus_w.rd_vld), 64'd1);

    // Coincident snapshot: event in the snapshot cycle lands in the new interval.
    events_s(0, 10, 10);
    evt_vld_s[0] = 1'b1;
    evt_inc_s[0 +: INC_W] = 4'd3;
    snap_s("coinc");
    evt_vld_s = '0;
    evt_inc_s = '0;
    read_s(6'd0);
    check("coinc_shadow", 64'(bus_s.rd_data), 64'd100);
    snap_s("coinc2");
    read_s(6'd0);
    check("coinc_next_interval", 64'(bus_s.rd_data), 64'd3);

    // Read/snapshot collision returns the pre-snapshot shadow.
    events_s(1, 7, 1);
    snap_s("coll_pre");
    events_s(1, 9, 1);
    bus_s.snap_req = 1'b1;
    bus_s.rd_req = 1'b1;
    bus_s.rd_addr = 6'd1;
    tick();
    bus_s.snap_req = 1'b0;
    bus_s.rd_req = 1'b0;
    check("coll_rd_data", 64'(bus_s.rd_data), 64'd7);
    check("coll_snap_done", 64'(bus_s.snap_done), 64'd1);
    read_s(6'd1);
    check("coll_next_read", 64'(bus_s.rd_data), 64'd9);
    tick();
    check("hold_rd_vld", 64'(bus_s.rd_vld), 64'd0);
    check("hold_rd_data", 64'(bus_s.rd_data), 64'd9);

    // Back-to-back snapshots: the second captures the restarted (zero) count.
    events_s(5, 4, 2);
    snap_s("b2b_first");
    snap_s("b2b_second");
    tick();
    check("b2b_done_drop", 64'(bus_s.snap_done), 64'd0);
    read_s(6'd5);
    check("b2b_rd_data", 64'(bus_s.rd_data), 64'd0);

    // Overflow flag: set wins over a simultaneous clear.
    events_s(9, 18, 15);
    check("ovfl9_set", 64'(ovfl_sticky_s[9]), 64'd1);
    evt_vld_s[9] = 1'b1;
    evt_inc_s[9*INC_W +: INC_W] = 4'd15;
    ovfl_clr_s[9] = 1'b1;
    tick();
    evt_vld_s = '0;
    evt_inc_s = '0;
    check("ovfl9_set_wins", 64'(ovfl_sticky_s[9]), 64'd1);
    tick();
    ovfl_clr_s = '0;
    check("ovfl9_cleared", 64'(ovfl_sticky_s[9]), 64'd0);

    // Sticky errors.
    err_in_s[5] = 1'b1;
    tick();
    err_in_s = '0;
    check("err5_set", 64'(err_sticky_s), 64'h0020);
    tick();
    check("err5_hold", 64'(err_sticky_s), 64'h0020);
    err_in_s[5] = 1'b1;
    err_clr_s[5] = 1'b1;
    tick();
    err_in_s = '0;
    check("err5_set_wins", 64'(err_sticky_s), 64'h0020);
    tick();
    err_clr_s = '0;
    check("err5_cleared", 64'(err_sticky_s), 64'h0000);

    // Reset mid-stream with a snapshot and read in flight.
    events_s(1, 6, 1);
    snap_s("rst_pre");
    err_in_s[3] = 1'b1;
    bus_s.snap_req = 1'b1;
    bus_s.rd_req = 1'b1;
    bus_s.rd_addr = 6'd1;
    tick();
    check("pre_rst_rd_data", 64'(bus_s.rd_data), 64'd6);
    check("pre_rst_err", 64'(err_sticky_s), 64'h0008);
    rst_n = 1'b0;
    #1;
    check("async_rst_rd_data", 64'(bus_s.rd_data), 64'd0);
    check("async_rst_rd_vld", 64'(bus_s.rd_vld), 64'd0);
    check("async_rst_snap_done", 64'(bus_s.snap_done), 64'd0);
    check("async_rst_err", 64'(err_sticky_s), 64'd0);
    check("async_rst_ovfl", 64'(ovfl_sticky_s), 64'd0);
    tick();
    err_in_s = '0;
    bus_s.snap_req = 1'b0;
    bus_s.rd_req = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_snap_done", 64'(bus_s.snap_done), 64'd0);
    check("post_rst_rd_vld", 64'(bus_s.rd_vld), 64'd0);
    read_s(6'd1);
    check("post_rst_shadow", 64'(bus_s.rd_data), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jb_oran_lphy_stat_cnt_bank.md
Name: jb_oran_lphy_stat_cnt_bank

Overview:
- Parametrised successor to the fixed O-RAN LPHY statistics bundle.
- Owns NUM_CNT event counters and NUM_ERR sticky error flags for the DL/UL/PRACH O-RAN LPHY paths.
- Supports atomic snapshot into shadow registers, optional clear-on-snapshot, saturate or wrap arithmetic, and a registered single-port read interface for the regmap.
- Sits between the LPHY datapath event sources and the register block; replaces hand-wired 32-bit count signals.

Parameters:
- NUM_CNT, 25, number of event counters (1..64).
- CNT_W, 32, counter width in bits (8..48).
- INC_W, 4, width of the per-event increment value (1..8).
- NUM_ERR, 16, number of sticky error flags (1..64).
- SAT_MODE, 1, 1 = saturate at all-ones; 0 = wrap modulo 2^CNT_W.
- CLR_ON_SNAP, 1, 1 = live counters restart on snapshot; 0 = counters free-run.
- ADDR_W, 6, read address width; must satisfy 2^ADDR_W >= NUM_CNT.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- evt_vld  in  NUM_CNT  per-counter increment strobe.
- evt_inc  in  NUM_CNT*INC_W  per-counter increment amount; sampled only when the matching evt_vld bit is 1.
- snap_req  in  1  single-cycle snapshot request.
- snap_done  out  1  one-cycle pulse, one cycle after snap_req is sampled.
- rd_req  in  1  read strobe.
- rd_addr  in  ADDR_W  counter index to read.
- rd_vld  out  1  read data valid, one cycle after rd_req.
- rd_data  out  CNT_W  shadow value of the addressed counter.
- rd_err  out  1  asserted with rd_vld when rd_addr >= NUM_CNT.
- err_in  in  NUM_ERR  raw error pulses or levels.
- err_clr  in  NUM_ERR  write-1-to-clear for sticky error flags.
- err_sticky  out  NUM_ERR  sticky error flags.
- ovfl_clr  in  NUM_CNT  write-1-to-clear for overflow flags.
- ovfl_sticky  out  NUM_CNT  per-counter overflow/saturation flag.

Behaviour:
- Reset: all live counters, shadows, err_sticky, ovfl_sticky, rd_data, rd_vld, rd_err and snap_done are 0.
- Increment:
  - If evt_vld[i], the next live value is live[i] + zero-extended evt_inc[i], computed in CNT_W+1 bits.
  - On carry-out with SAT_MODE=1: live[i] becomes all-ones, and stays there on further events.
  - On carry-out with SAT_MODE=0: the sum is truncated to CNT_W.
  - In both modes a carry-out sets ovfl_sticky[i].
  - evt_inc = 0 with evt_vld = 1 leaves the count unchanged.
- Snapshot, at the edge where snap_req = 1:
  - shadow[i] <= live[i] (the pre-edge value) for all i, atomically.
  - CLR_ON_SNAP=1: live[i] <= 0 + (evt_vld[i] ? evt_inc[i] : 0). A coincident event is counted in the new interval, never lost.
  - CLR_ON_SNAP=0: live[i] updates normally.
  - snap_done pulses one cycle later.
  - Back-to-back snap_req is legal; each one takes its own snapshot.
- Read:
  - rd_req sampled at edge N gives rd_vld = 1 with rd_data = shadow[rd_addr] during cycle N+1.
  - If rd_req and snap_req are sampled at the same edge, the read returns the pre-snapshot shadow.
  - Out-of-range address: rd_data = 0, rd_err = 1.
  - rd_data holds its value when rd_vld = 0.
- Sticky errors: err_sticky[j] <= (err_sticky[j] & ~err_clr[j]) | err_in[j]. Set wins over a simultaneous clear.
- Overflow flags: same rule as sticky errors, using ovfl_clr and the internal carry-out. Set wins.
- Reset mid-operation: everything clears asynchronously; a pending snapshot or read is discarded and no snap_done or rd_vld is produced.
- No state machine beyond the single-cycle snapshot/read pipelines. The bank is fully pipelined: one snapshot and one read accepted per cycle.

Decomposition:
- Package jb_oran_lphy_stat_pkg holds:
  - counter index localparams, e.g. CNT_RUNT_T0, CNT_WIN_T2_T1_DL, CNT_T1_REQS_UL0, ...
  - error index localparams, e.g. ERR_UL_VLD_WO_RDY0, ERR_PRACH_CPLANE_OVFL0, ERR_SECT_WR_TOO_LONG;
  - default NUM_CNT / NUM_ERR;
  - typedef cnt_t of logic [CNT_W-1:0].
- Sub-module jb_oran_lphy_stat_cnt: one counter holding live, shadow and ovfl, with SAT_MODE/CLR_ON_SNAP behaviour. It is instantiated NUM_CNT times via generate.
- The top level handles the read mux, the sticky errors and snap_done.

Test Plan:
- Increment: CNT_W=8, SAT_MODE=1; 20 events of inc=15 on counter 3, then snap_req, then read addr 3 -> rd_data = 0xFF, ovfl_sticky[3] = 1. Then ovfl_clr[3] -> 0.
- Wrap: CNT_W=8, SAT_MODE=0; live = 250, event inc = 10 -> live = 4, ovfl_sticky = 1. Snapshot, then read -> 4.
- Coincident snapshot: CLR_ON_SNAP=1, counter 0 = 100; snap_req together with evt_vld[0], inc = 3 -> shadow = 100, live = 3; snap_done one cycle later. The next snapshot reads back 3.
- Read/snapshot collision: shadow[1] = 7, live = 9; rd_req(addr=1) together with snap_req -> rd_data = 7 at N+1. A read at N+1 returns 9 at N+2.
- Out-of-range read: NUM_CNT = 25, rd_addr = 30 -> rd_vld = 1, rd_err = 1, rd_data = 0.
- Sticky errors: err_in[5] pulse -> err_sticky[5] = 1 holds. err_clr[5] together with err_in[5] -> stays 1. err_clr alone -> 0. Assert rst_n = 0 mid-stream -> all outputs 0 immediately.
